// File: rtl/shifter_defs.sv
// Shared definitions for the pipelined barrel shifter: mode encodings and a
// constant-evaluable ceil(log2) used to size the shift amount.
package shifter_defs;

    localparam logic [1:0] MODE_LSR = 2'b00;
    localparam logic [1:0] MODE_ASR = 2'b01;
    localparam logic [1:0] MODE_LSL = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/shift_level.sv
// One radix-4 shift level: shifts by d*STEP in the selected mode. Every output
// bit is a four-way select among the bits reachable by the four digit values.
module shift_level
    import shifter_defs::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [1:0]       d_i,
    input  logic [1:0]       mode_i,
    input  logic             sign_i,
    output logic [WIDTH-1:0] data_o
);

    logic is_lsl;
    logic is_ror;
    logic fill_bit;

    assign is_lsl   = (mode_i == MODE_LSL);
    assign is_ror   = (mode_i == MODE_ROR);
    assign fill_bit = (mode_i == MODE_ASR) && sign_i;

    for (genvar j = 0; j < WIDTH; j++) begin : g_bit
        logic [3:0] cand;

        for (genvar k = 0; k < 4; k++) begin : g_cand
            localparam int SH = k * STEP;
            logic right_bit;
            logic left_bit;

            // Right-going modes pull from above; past the msb it is fill or wrap.
            if (j + SH < WIDTH) begin : g_rin
                assign right_bit = data_i[j + SH];
            end else begin : g_rout
                assign right_bit = is_ror ? data_i[(j + SH) % WIDTH] : fill_bit;
            end

            if (j >= SH) begin : g_lin
                assign left_bit = data_i[j - SH];
            end else begin : g_lout
                assign left_bit = 1'b0;
            end

            assign cand[k] = is_lsl ? left_bit : right_bit;
        end

        assign data_o[j] = cand[d_i];
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined LSR/ASR/LSL/ROR shifter built from registered radix-4 levels with
// a valid/ready handshake; the whole pipe stalls as one when the output is blocked.
module pipelined_barrel_shifter
    import shifter_defs::*;
#(
    parameter  int WIDTH = 16,
    localparam int SHW   = clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    localparam int LEVELS = (SHW + 1) / 2;
    localparam int AMTW   = 2 * LEVELS;

    logic            advance;
    logic [AMTW-1:0] amt_pad;

    logic [WIDTH-1:0] lvl_in_data [LEVELS];
    logic [1:0]       lvl_in_d    [LEVELS];
    logic [1:0]       lvl_in_mode [LEVELS];
    logic             lvl_in_sign [LEVELS];
    logic [WIDTH-1:0] lvl_out     [LEVELS];

    logic             valid_q [LEVELS];
    logic             valid_d [LEVELS];
    logic [WIDTH-1:0] data_q  [LEVELS];
    logic [WIDTH-1:0] data_d  [LEVELS];
    logic [1:0]       mode_q  [LEVELS];
    logic [1:0]       mode_d  [LEVELS];
    logic             sign_q  [LEVELS];
    logic             sign_d  [LEVELS];
    logic [AMTW-1:0]  amt_q   [LEVELS];
    logic [AMTW-1:0]  amt_d   [LEVELS];
    logic             zero_q;
    logic             zero_d;

    logic unused_sideband;

    assign amt_pad   = AMTW'(in_amt);
    assign advance   = !valid_q[LEVELS-1] || out_ready;
    assign in_ready  = advance;
    assign out_valid = valid_q[LEVELS-1];
    assign out_data  = data_q[LEVELS-1];
    assign out_zero  = zero_q;

    for (genvar i = 0; i < LEVELS; i++) begin : g_level
        if (i == 0) begin : g_head
            assign lvl_in_data[i] = in_data;
            assign lvl_in_d[i]    = amt_pad[1:0];
            assign lvl_in_mode[i] = in_mode;
            assign lvl_in_sign[i] = in_data[WIDTH-1];
        end else begin : g_tail
            assign lvl_in_data[i] = data_q[i-1];
            assign lvl_in_d[i]    = amt_q[i-1][1:0];
            assign lvl_in_mode[i] = mode_q[i-1];
            assign lvl_in_sign[i] = sign_q[i-1];
        end

        shift_level #(
            .WIDTH (WIDTH),
            .STEP  (4 ** i)
        ) u_level (
            .data_i (lvl_in_data[i]),
            .d_i    (lvl_in_d[i]),
            .mode_i (lvl_in_mode[i]),
            .sign_i (lvl_in_sign[i]),
            .data_o (lvl_out[i])
        );
    end

    // Amount digits are consumed two bits per level, so each stage carries the rest down.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        mode_d  = mode_q;
        sign_d  = sign_q;
        amt_d   = amt_q;
        zero_d  = zero_q;
        if (advance) begin
            valid_d[0] = in_valid;
            data_d[0]  = lvl_out[0];
            mode_d[0]  = in_mode;
            sign_d[0]  = in_data[WIDTH-1];
            amt_d[0]   = amt_pad >> 2;
            for (int i = 1; i < LEVELS; i++) begin
                valid_d[i] = valid_q[i-1];
                data_d[i]  = lvl_out[i];
                mode_d[i]  = mode_q[i-1];
                sign_d[i]  = sign_q[i-1];
                amt_d[i]   = amt_q[i-1] >> 2;
            end
            zero_d = (lvl_out[LEVELS-1] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LEVELS; i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= '0;
                mode_q[i]  <= '0;
                sign_q[i]  <= 1'b0;
                amt_q[i]   <= '0;
            end
            zero_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            sign_q  <= sign_d;
            amt_q   <= amt_d;
            zero_q  <= zero_d;
        end
    end

    // The last stage's sideband and the exhausted amount bits have no consumer.
    always_comb begin
        unused_sideband = ^mode_q[LEVELS-1] ^ sign_q[LEVELS-1];
        for (int i = 0; i < LEVELS; i++) begin
            unused_sideband = unused_sideband ^ (^amt_q[i]);
        end
    end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter (WIDTH=16): directed corner
// cases, stall/hold, mid-stream reset, then randomized throttled traffic.
module tb_pipelined_barrel_shifter;
    import shifter_defs::*;

    localparam int W = 16;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [3:0]    in_amt;
    logic [1:0]    in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_zero;

    typedef struct packed {
        logic [W-1:0] data;
        logic         zero;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_bad = 0;
    logic rnd_done;

    logic [W-1:0] stall_d [4] = '{16'hF00F, 16'h1234, 16'h8001, 16'hABCD};
    logic [3:0]   stall_a [4] = '{4'd3, 4'd9, 4'd15, 4'd6};
    logic [1:0]   stall_m [4] = '{MODE_ASR, MODE_ROR, MODE_LSL, MODE_LSR};

    pipelined_barrel_shifter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain shift operators on the whole operand.
    function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [3:0] a,
                                           input logic [1:0] m);
        logic [2*W-1:0] dd;
        logic [W-1:0]   r;
        case (m)
            MODE_LSR: r = d >> a;
            MODE_ASR: r = W'($signed(d) >>> a);
            MODE_LSL: r = d << a;
            default: begin
                dd = {d, d} >> a;
                r  = dd[W-1:0];
            end
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got 0x%0h, required no beat", out_data);
                end else begin
                    mon_e = sb.pop_front();
                    check("sb_data", 32'(out_data), 32'(mon_e.data));
                    check("sb_zero", 32'(out_zero), 32'(mon_e.zero));
                end
            end
            if (in_valid && in_ready) begin
                mon_e.data = model(in_data, in_amt, in_mode);
                mon_e.zero = (mon_e.data == '0);
                sb.push_back(mon_e);
            end
        end
    end

    // Entered and left at posedge+1; holds the beat until the DUT takes it.
    task automatic send(input logic [W-1:0] d, input logic [3:0] a, input logic [1:0] m);
        int guard;
        guard    = 0;
        in_data  = d;
        in_amt   = a;
        in_mode  = m;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 1000) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 1000) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", guard);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((sb.size() != 0 || out_valid) && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int quiet;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_mode   = '0;
        out_ready = 1'b0;
        rnd_done  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_zero", 32'(out_zero), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Latency: result visible after the second edge following the drive.
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_data   = 16'h8001;
        in_amt    = 4'd1;
        in_mode   = MODE_LSR;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_not_yet", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_data", 32'(out_data), 32'h4000);
        @(posedge clk);
        #1;

        send(16'h8000, 4'd15, MODE_ASR);
        send(16'h7FFF, 4'd15, MODE_ASR);
        send(16'h1234, 4'd4, MODE_ROR);
        send(16'h0001, 4'd15, MODE_LSL);
        send(16'h0000, 4'd7, MODE_LSR);
        send(16'h7A5C, 4'd5, MODE_ASR);
        for (int m = 0; m < 4; m++) send(16'hC3A5, 4'd0, 2'(m));
        drain();
        check("asr_neg15", 32'(model(16'h8000, 4'd15, MODE_ASR)), 32'hFFFF);

        // Stall: four back-to-back beats, output blocked three cycles after the first result.
        out_ready = 1'b1;
        fork
            begin
                for (int b = 0; b < 4; b++) send(stall_d[b], stall_a[b], stall_m[b]);
            end
            begin
                int g;
                g = 0;
                @(negedge clk);
                while (!out_valid && g < 20) begin
                    g++;
                    @(negedge clk);
                end
                check("stall_first_seen", 32'(out_valid), 32'd1);
                check("stall_first_data", 32'(out_data),
                      32'(model(stall_d[0], stall_a[0], stall_m[0])));
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_hold", 32'(out_data),
                          32'(model(stall_d[1], stall_a[1], stall_m[1])));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight and the output blocked.
        out_ready = 1'b0;
        send(16'h5555, 4'd2, MODE_LSL);
        send(16'hFFFF, 4'd1, MODE_LSR);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_data", 32'(out_data), 32'd0);
        out_ready = 1'b1;
        quiet = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) quiet++;
        end
        check("midrst_no_stale", 32'(quiet), 32'd0);
        @(posedge clk);
        #1;

        // Random traffic with random source gaps and sink back-pressure.
        fork
            begin
                for (int n = 0; n < 10000; n++) begin
                    while ($urandom_range(0, 3) == 0) begin
                        in_data = 16'($urandom);
                        in_amt  = 4'($urandom);
                        in_mode = 2'($urandom);
                        @(posedge clk);
                        #1;
                    end
                    send(16'($urandom), 4'($urandom), 2'($urandom));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
